// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial add/subtract sequencer wrapped around an
// external single-bit full adder. Operands are shifted out LSB first, the
// returned sum bits are shifted into the result register from the top, and
// the final carry is kept as the carry-out.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_y,
  input  logic             fa_s,
  input  logic             fa_c
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             sub_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             inRun;

  // Sequencer: load operands in IDLE, run one bit per cycle, pulse done once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= sub;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= {fa_s, res_q[WIDTH-1:1]};
          carry_q <= fa_c;
          a_q     <= {1'b0, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            cout_q  <= fa_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Full-adder drive comes straight from registers and is forced low outside RUN.
  always_comb begin
    inRun = (state_q == RUN);
    fa_a  = inRun & a_q[0];
    fa_b  = inRun & (b_q[0] ^ sub_q);
    fa_y  = inRun & carry_q;
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Testbench for serial_adder_seq: an 8-bit and a 2-bit instance, each wired
// to a behavioural full adder. Stimulus pushes expected {cout,result} into a
// queue; monitors pop and compare whenever done pulses.
module tb_serial_adder_seq;

  logic       clk;
  logic       reset;

  // 8-bit instance signals
  logic       start;
  logic       sub;
  logic [7:0] opA;
  logic [7:0] opB;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       faA, faB, faY, faS, faC;

  // 2-bit instance signals
  logic       start2;
  logic [1:0] opA2;
  logic [1:0] opB2;
  logic       busy2;
  logic       done2;
  logic [1:0] result2;
  logic       cout2;
  logic       faA2, faB2, faY2, faS2, faC2;

  int errors = 0;
  int checks = 0;

  logic [8:0] expQ8[$];
  logic [2:0] expQ2[$];

  serial_adder_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub),
    .op_a(opA), .op_b(opB), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .fa_a(faA), .fa_b(faB), .fa_y(faY), .fa_s(faS), .fa_c(faC)
  );

  serial_adder_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .sub(1'b0),
    .op_a(opA2), .op_b(opB2), .cin(1'b0),
    .busy(busy2), .done(done2), .result(result2), .cout(cout2),
    .fa_a(faA2), .fa_b(faB2), .fa_y(faY2), .fa_s(faS2), .fa_c(faC2)
  );

  // Behavioural full adders standing in for the shared full-adder stage
  assign faS  = faA ^ faB ^ faY;
  assign faC  = (faA & faB) | (faA & faY) | (faB & faY);
  assign faS2 = faA2 ^ faB2 ^ faY2;
  assign faC2 = (faA2 & faB2) | (faA2 & faY2) | (faB2 & faY2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: every done must match a queued expectation
  always @(negedge clk) begin
    if (done) begin
      if (expQ8.size() == 0) begin
        checkOutput("unexpected_done8", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = expQ8.pop_front();
        checkOutput("result8", {24'd0, result}, {24'd0, e[7:0]});
        checkOutput("cout8", {31'd0, cout}, {31'd0, e[8]});
      end
    end
  end

  // Monitor for the 2-bit instance
  always @(negedge clk) begin
    if (done2) begin
      if (expQ2.size() == 0) begin
        checkOutput("unexpected_done2", 32'd1, 32'd0);
      end else begin
        logic [2:0] e;
        e = expQ2.pop_front();
        checkOutput("result2", {30'd0, result2}, {30'd0, e[1:0]});
        checkOutput("cout2", {31'd0, cout2}, {31'd0, e[2]});
      end
    end
  end

  // Issue one 8-bit operation; optionally keep start high and scramble operands during RUN
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic ci,
                               input logic s, input logic [7:0] expR, input logic expC,
                               input bit toggle);
    int k;
    int busyCnt;
    int guard;
    guard = 0;
    while ((busy || done) && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    opA   = a;
    opB   = b;
    cin   = ci;
    sub   = s;
    start = 1'b1;
    expQ8.push_back({expC, expR});
    @(posedge clk);
    #1;
    if (!toggle) start = 1'b0;
    busyCnt = busy ? 1 : 0;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      k++;
      #1;
      if (toggle) begin
        opA = ~opA;
        opB = opB + 8'h37;
        cin = ~cin;
        sub = ~sub;
      end
      if (done) break;
      if (busy) busyCnt++;
    end
    start = 1'b0;
    checkOutput("done_latency", k, 8);
    checkOutput("busy_cycles", busyCnt, 8);
  endtask

  initial begin
    int k;
    reset  = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    opA    = '0;
    opB    = '0;
    cin    = 1'b0;
    start2 = 1'b0;
    opA2   = '0;
    opB2   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_done", {31'd0, done}, 0);
    checkOutput("rst_result", {24'd0, result}, 0);
    checkOutput("rst_cout", {31'd0, cout}, 0);
    checkOutput("rst_fa", {29'd0, faA, faB, faY}, 0);
    checkOutput("rst_result2", {30'd0, result2}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b1);

    // Result must hold while IDLE with no start
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_result", {24'd0, result}, 32'h46);
    checkOutput("idle_busy", {31'd0, busy}, 0);

    // Reset during RUN cycle 4 of 0xAA+0x55: outputs clear without a clock edge
    opA   = 8'hAA;
    opB   = 8'h55;
    cin   = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 0);
    checkOutput("midrst_result", {24'd0, result}, 0);
    checkOutput("midrst_cout", {31'd0, cout}, 0);
    checkOutput("midrst_fa", {29'd0, faA, faB, faY}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // 2-bit instance: 3+3 wraps to 2 with carry out
    opA2   = 2'h3;
    opB2   = 2'h3;
    start2 = 1'b1;
    expQ2.push_back({1'b1, 2'h2});
    @(posedge clk);
    #1;
    start2 = 1'b0;
    k = 0;
    while (k < 20) begin
      @(posedge clk);
      k++;
      #1;
      if (done2) break;
    end
    checkOutput("done2_latency", k, 2);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("q8_drained", expQ8.size(), 0);
    checkOutput("q2_drained", expQ2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial add/subtract sequencer that drives the single-bit full-adder stage. It loads two WIDTH-bit operands and presents one bit pair plus the running carry to the full adder each cycle, LSB first. It captures the returned sum bit and carry, and after WIDTH cycles presents the parallel result and carry-out. It is the control and datapath stage directly upstream and downstream of the full adder; the multiplier's partial-product accumulation is built on it.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..16.

- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request new operation; sampled only in IDLE.
- sub  input  1  0 = A+B+cin, 1 = A−B (B inverted, carry seeded 1, cin ignored); sampled with start.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add; sampled with start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  WIDTH  sum/difference; valid from done until the next accepted start.
- cout  output  1  final carry; for sub, 1 = no borrow.
- fa_a  output  1  to full adder a.
- fa_b  output  1  to full adder b.
- fa_y  output  1  to full adder carry-in y.
- fa_s  input  1  sum from full adder; combinational from fa_a/fa_b/fa_y.
- fa_c  input  1  carry from full adder; combinational from fa_a/fa_b/fa_y.

## Operation
- Registers:
  - a_sh, b_sh (WIDTH).
  - res_sh (WIDTH).
  - carry_q.
  - sub_q.
  - cnt (clog2(WIDTH+1) bits).
  - cout_q.
  - state (IDLE, RUN, DONE).
- Reset (async, immediate):
  - state=IDLE; all registers 0.
  - busy=0, done=0, result=0, cout=0, fa_a=fa_b=fa_y=0.
- IDLE:
  - If start=1: a_sh←op_a, b_sh←op_b, sub_q←sub, carry_q←(sub ? 1 : cin), cnt←0, res_sh←0; next state RUN.
  - If start=0: hold state; result and cout retain the last values.
- RUN (combinational drive): fa_a=a_sh[0], fa_b=b_sh[0]^sub_q, fa_y=carry_q.
- RUN (each edge):
  - res_sh←{fa_s, res_sh[WIDTH-1:1]}.
  - carry_q←fa_c.
  - a_sh, b_sh shift right by 1, MSB filled with 0.
  - cnt←cnt+1.
  - When cnt==WIDTH-1 at the edge: cout_q←fa_c and next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- Outputs:
  - result=res_sh; cout=cout_q.
  - fa_a/fa_b/fa_y=0 outside RUN.
- start in RUN or DONE: ignored, no queuing. Operand input changes after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH. Overflow is reported only through cout; there is no signed overflow flag.

## Timing
- Edge E0: start is sampled in IDLE. RUN occupies the cycles after edges E0..E(WIDTH−1).
- Bit i is presented during the cycle after edge Ei and captured at edge E(i+1).
- DONE is entered at edge EWIDTH; done is high during the cycle following EWIDTH. Latency is WIDTH+1 edges from start to done.
- Next start is accepted at the edge after done falls (IDLE). Minimum period is WIDTH+2 cycles per operation.
- Reset asserted mid-RUN or in DONE: the operation is abandoned and the result is cleared, with no done pulse. After reset deasserts, the first accepted start behaves normally.
- No combinational path from start/op_* to any output. fa_* depend only on registers.

## Test plan
Bench connects fa_* to the team's full-adder module; WIDTH=8.
- 0x5A + 0x3C, cin=0, sub=0 -> result 0x96, cout 0; done exactly 9 edges after start; busy high for 8 cycles.
- 0xFF + 0x01, cin=0 -> result 0x00, cout 1. Then 0x00 + 0x00, cin=1 -> result 0x01, cout 0.
- sub: 0x10 − 0x01 -> 0x0F, cout 1. Then 0x00 − 0x01 -> 0xFF, cout 0 (borrow); the cin input is driven 1 and has no effect.
- start held high and op_a/op_b toggled every cycle during RUN -> result equals operands sampled at E0. Exactly one done per accepted start; next op starts only after IDLE.
- reset pulse during RUN cycle 4 of 0xAA+0x55 -> busy, result, cout, fa_* go 0 without waiting for a clock edge; no done. A subsequent 0x01+0x02 gives 0x03.
- WIDTH=2 build: 0x3+0x3 -> result 0x2, cout 1; done 3 edges after start.
